pe_mac_acc: RTL
===============

PE_MAC_ACC -- requirements
Module: pe_mac_acc

Interface
REQ-001 SHALL have parameter LANES, default 4, number of multiply lanes; a power of two, at least 2.
REQ-002 SHALL have parameter DW, default 8, signed ifm/wgt element width.
REQ-003 SHALL have parameter ACC_W, default 25, signed accumulator and p_sum width; at least 2*DW+log2(LANES).
REQ-004 SHALL have parameter APPROX_BITS, default 6, number of approximated LSBs per tree adder; 0 means exact.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit, input beat valid.
REQ-008 SHALL have port in_first, input, 1 bit, beat opens an accumulation window; qualified by in_valid.
REQ-009 SHALL have port in_last, input, 1 bit, beat closes the window; qualified by in_valid.
REQ-010 SHALL have port ifm, input, LANES*DW bits, lane k at bits [k*DW +: DW], signed.
REQ-011 SHALL have port wgt, input, LANES*DW bits, same packing as ifm, signed.
REQ-012 SHALL have port p_sum, output, ACC_W bits, signed window result.
REQ-013 SHALL have port out_valid, output, 1 bit, one-cycle pulse marking p_sum valid.
REQ-014 SHALL have port ovf, output, 1 bit, saturation occurred in the reported window; valid with out_valid.

Function
REQ-015 Stage P SHALL register the LANES signed 2*DW-bit products ifm[k]*wgt[k].
REQ-016 Tree stages T1..Tlog2(LANES) SHALL each register pairwise sums, one bit wider per level, sign-extended; stage A accumulates.
REQ-017 Latency from an in_valid beat to its out_valid SHALL be log2(LANES)+2 cycles (4 cycles for LANES=4).
REQ-018 The valid, first, and last tags SHALL travel with the data through every stage; no backpressure; a beat is accepted every cycle in_valid=1.
REQ-019 In stage A, a beat with first=1 SHALL load acc with the sign-extended tree sum and clear the sticky overflow.
REQ-020 In stage A, a beat with first=0 SHALL set acc to sat(acc + tree sum), saturating to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and set sticky overflow on clipping.
REQ-021 A beat with last=1 SHALL, on the same edge, load p_sum with the new acc and ovf with the new sticky value, and pulse out_valid=1 for one cycle.
REQ-022 first=1 together with last=1 SHALL form a single-beat window.
REQ-023 A bubble (valid=0) at stage A SHALL hold acc, sticky, p_sum, and ovf.
REQ-024 last without a preceding first SHALL accumulate onto the current acc, with no special handling.
REQ-025 p_sum and ovf SHALL hold their value between out_valid pulses.
REQ-026 The accumulator adder SHALL always be exact; only tree adders use approximation (REQ-031).

Reset
REQ-027 rst=1 SHALL clear all product, tree, tag, acc, and sticky registers, and set p_sum=0, out_valid=0, and ovf=0 at the next edge.
REQ-028 Assertion of rst mid-window SHALL discard all in-flight beats; no out_valid SHALL be produced for them.
REQ-029 Beats presented while rst=1 SHALL be ignored.

Configuration
REQ-030 Macro PE_APPROX_EN SHALL select tree adder type.
REQ-031 With PE_APPROX_EN defined, each tree adder SHALL be a lower-part-OR adder:
- sum[APPROX_BITS-1:0] = a|b;
- the upper part is an exact add with carry-in a[APPROX_BITS-1] & b[APPROX_BITS-1].
REQ-032 Without PE_APPROX_EN, all tree adders SHALL be exact, and APPROX_BITS SHALL be ignored.

Verification (LANES=4, DW=8, ACC_W=25, APPROX_BITS=6)
REQ-033 Exact build: ifm={1,2,3,4}, wgt={1,1,1,1}, first=last=1 -> out_valid 4 cycles later, p_sum=10, ovf=0.
REQ-034 Exact build: all lanes -128*-128 for 3 beats (first on beat 0, last on beat 2) with an idle cycle between beats 1 and 2 -> p_sum=196608, single out_valid pulse.
REQ-035 Exact build: all lanes -128*-128 for 256 beats in one window -> p_sum=16777215, ovf=1; next single-beat window with ifm={1,0,0,0}, wgt={1,0,0,0} -> p_sum=1, ovf=0.
REQ-036 Back-to-back windows: {first,last} single beats of 5 and -7 on consecutive cycles -> consecutive out_valid pulses with p_sum=5 then -7.
REQ-037 rst=1 for one cycle two cycles after a first beat, then last beat -> no out_valid from the aborted window; all outputs read 0 after reset.
REQ-038 ifm={1,1,0,0}, wgt={1,1,0,0}, single beat -> p_sum=1 with PE_APPROX_EN, p_sum=2 without.

Source files
------------

// File: rtl/pe_mac_acc.sv
// pe_mac_acc: LANES-wide signed multiply, pipelined adder tree, and a
// windowed saturating accumulator. Each beat's valid/first/last tags travel
// through the pipeline alongside its data.
// Optional feature macro: PE_APPROX_EN turns every tree adder into a
// lower-part-OR adder over the low APPROX_BITS bits. The accumulator adder
// is always exact. When the macro is undefined, every adder is exact.
module pe_mac_acc #(
  parameter int LANES       = 4,
  parameter int DW          = 8,
  parameter int ACC_W       = 25,
  parameter int APPROX_BITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [LANES*DW-1:0]     ifm,
  input  logic [LANES*DW-1:0]     wgt,
  output logic signed [ACC_W-1:0] p_sum,
  output logic                    out_valid,
  output logic                    ovf
);

  localparam int LVL = $clog2(LANES);
  // Tree values are all kept at the final tree width. Each adder works on
  // sign-extended operands, so its result equals the sign extension of the
  // narrower per-level sum.
  localparam int TW  = 2*DW + LVL;
  // Number of approximated low bits; zero makes the tree adder exact.
  localparam int AB  =
`ifdef PE_APPROX_EN
    APPROX_BITS;
`else
    0;
`endif

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Tree adder. The low AB bits are OR'ed together. The carry into the exact
  // upper part is the AND of the two operand bits at position AB-1. With
  // AB == 0, this is a plain ripple-carry exact add.
  function automatic logic signed [TW-1:0] tree_add(
    input logic signed [TW-1:0] a,
    input logic signed [TW-1:0] b
  );
    logic [TW-1:0] s;
    logic          c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < TW; i++) begin
      if (i < AB) begin
        s[i] = a[i] | b[i];
        c    = a[i] & b[i];
      end else begin
        s[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    return signed'(s);
  endfunction

  logic signed [2*DW-1:0] prod [LANES];
  logic signed [TW-1:0]   tree [LVL+1][LANES];
  logic [LVL:0]           vld;
  logic [LVL:0]           fst;
  logic [LVL:0]           lst;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] tsum;
  logic signed [ACC_W:0]   wide;
  logic                    clip;
  logic                    sticky;
  logic                    sticky_nxt;

  // Per-lane signed products at full 2*DW width
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod[k] = (2*DW)'($signed(ifm[k*DW +: DW])) * (2*DW)'($signed(wgt[k*DW +: DW]));
    end
  end

  // Product stage, adder-tree stages, and the tags that travel with them
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      fst <= '0;
      lst <= '0;
      for (int l = 0; l <= LVL; l++) begin
        for (int j = 0; j < LANES; j++) begin
          tree[l][j] <= '0;
        end
      end
    end else begin
      vld[0] <= in_valid;
      fst[0] <= in_valid & in_first;
      lst[0] <= in_valid & in_last;
      for (int l = 1; l <= LVL; l++) begin
        vld[l] <= vld[l-1];
        fst[l] <= fst[l-1];
        lst[l] <= lst[l-1];
      end
      for (int k = 0; k < LANES; k++) begin
        tree[0][k] <= TW'(prod[k]);
      end
      for (int l = 1; l <= LVL; l++) begin
        for (int j = 0; j < LANES; j++) begin
          if (j < (LANES >> l)) begin
            tree[l][j] <= tree_add(tree[l-1][(2*j) % LANES], tree[l-1][(2*j+1) % LANES]);
          end else begin
            tree[l][j] <= '0;
          end
        end
      end
    end
  end

  // Next accumulator value: load on first, otherwise an exact add clipped to the accumulator range
  always_comb begin
    tsum       = ACC_W'(tree[LVL][0]);
    wide       = (ACC_W+1)'(acc) + (ACC_W+1)'(tsum);
    clip       = wide[ACC_W] != wide[ACC_W-1];
    acc_nxt    = acc;
    sticky_nxt = sticky;
    if (fst[LVL]) begin
      acc_nxt    = tsum;
      sticky_nxt = 1'b0;
    end else if (clip) begin
      acc_nxt    = wide[ACC_W] ? ACC_MIN : ACC_MAX;
      sticky_nxt = 1'b1;
    end else begin
      acc_nxt    = wide[ACC_W-1:0];
      sticky_nxt = sticky;
    end
  end

  // Accumulator stage and window result registers; bubbles hold everything
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      sticky    <= 1'b0;
      p_sum     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld[LVL] & lst[LVL];
      if (vld[LVL]) begin
        acc    <= acc_nxt;
        sticky <= sticky_nxt;
        if (lst[LVL]) begin
          p_sum <= acc_nxt;
          ovf   <= sticky_nxt;
        end else begin
          p_sum <= p_sum;
          ovf   <= ovf;
        end
      end else begin
        acc    <= acc;
        sticky <= sticky;
        p_sum  <= p_sum;
        ovf    <= ovf;
      end
    end
  end

endmodule
